// File: rtl/cpu_pc_pkg.sv
// Shared definitions for the program-counter sequencer: address defaults,
// sequencer state encoding and the branch displacement helper.
package cpu_pc_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_4180;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } pc_state_e;

  // Word offset to byte displacement, sign-extended to the full PC width.
  function automatic logic [31:0] branch_disp(input logic [15:0] off);
    return {{14{off[15]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/pc_target_join.sv
// J-type jump target: keeps the 256 MB region of pc4 and replaces the rest
// with the word-aligned 26-bit index.
module pc_target_join (
  input  logic [3:0]  pc4_hi_i,
  input  logic [25:0] j_index_i,
  output logic [31:0] target_o
);

  assign target_o = {pc4_hi_i, j_index_i, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: fetches through a req/ack memory port, hands the
// word to decode over valid/ready, and applies branch/jump/exception redirects.
module pc_sequencer
  import cpu_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        id_ready,
  input  logic        br_take,
  input  logic [15:0] br_off,
  input  logic        j_take,
  input  logic [25:0] j_index,
  input  logic        jr_take,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  input  logic        halt,
  output logic [31:0] epc,
  output logic        halted
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        exc_pend_q, exc_pend_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;

  logic [31:0] pc4;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] redirect_pc;
  logic        redirect_exc;

  assign pc4           = instr_pc_q + 32'd4;
  assign branch_target = pc4 + branch_disp(br_off);

  pc_target_join u_target_join (
    .pc4_hi_i  (pc4[31:28]),
    .j_index_i (j_index),
    .target_o  (jump_target)
  );

  // Redirect chosen at the decode handshake; a misaligned JR target is
  // raised as an exception rather than fetched.
  always_comb begin
    redirect_exc = 1'b0;
    redirect_pc  = pc4;
    if (exc_req) begin
      redirect_exc = 1'b1;
      redirect_pc  = EXC_VECTOR;
    end else if (jr_take) begin
      if (jr_target[1:0] != 2'b00) begin
        redirect_exc = 1'b1;
        redirect_pc  = EXC_VECTOR;
      end else begin
        redirect_pc = jr_target;
      end
    end else if (j_take) begin
      redirect_pc = jump_target;
    end else if (br_take) begin
      redirect_pc = branch_target;
    end
  end

  // NOTE: every next-state signal gets its hold value first so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    epc_d         = epc_q;
    exc_pend_d    = exc_pend_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    case (state_q)
      FETCH: begin
        if (exc_req) begin
          epc_d = pc_q;
          pc_d  = EXC_VECTOR;
        end else begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (imem_ack) begin
          // An exception seen on or before the ack throws the fetched word away.
          if (exc_pend_q || exc_req) begin
            epc_d      = pc_q;
            pc_d       = EXC_VECTOR;
            exc_pend_d = 1'b0;
            state_d    = FETCH;
          end else begin
            instr_d       = imem_rdata;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
          end
        end else if (exc_req) begin
          exc_pend_d = 1'b1;
        end
      end

      HOLD: begin
        if (id_ready) begin
          instr_valid_d = 1'b0;
          pc_d          = redirect_pc;
          if (redirect_exc) begin
            epc_d = instr_pc_q;
          end
          state_d = (halt && !redirect_exc) ? HALTED : FETCH;
        end else if (exc_req) begin
          instr_valid_d = 1'b0;
          epc_d         = instr_pc_q;
          pc_d          = EXC_VECTOR;
          state_d       = FETCH;
        end
      end

      HALTED: begin
        state_d = HALTED;
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      epc_q         <= 32'h0;
      exc_pend_q    <= 1'b0;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      exc_pend_q    <= exc_pend_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // A request is withheld while reset is asserted and in the cycle an
  // exception retargets the pending fetch.
  assign imem_req    = !rst && (((state_q == FETCH) && !exc_req) || (state_q == WAIT));
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign epc         = epc_q;
  assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed redirect table, multi-cycle
// exception/halt/reset sequences, then randomized traffic against a model.
module tb_pc_sequencer;

  localparam logic [31:0] EXC_VEC = 32'h0000_4180;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        id_ready;
  logic        br_take;
  logic [15:0] br_off;
  logic        j_take;
  logic [25:0] j_index;
  logic        jr_take;
  logic [31:0] jr_target;
  logic        exc_req;
  logic        halt;
  logic [31:0] epc;
  logic        halted;

  pc_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .id_ready    (id_ready),
    .br_take     (br_take),
    .br_off      (br_off),
    .j_take      (j_take),
    .j_index     (j_index),
    .jr_take     (jr_take),
    .jr_target   (jr_target),
    .exc_req     (exc_req),
    .halt        (halt),
    .epc         (epc),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_miss;
  logic [31:0] exp_epc;
  logic [31:0] cur_hold;

  typedef struct {
    logic [31:0] hold_pc;
    logic        br;
    logic [15:0] off;
    logic        j;
    logic [25:0] idx;
    logic        jr;
    logic [31:0] tgt;
    logic        exc;
    logic [31:0] exp_next;
    logic        exp_exc;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[15:0], addr[31:16]} ^ 32'hC3C3_A5A5;
  endfunction

  // Reference next-PC rule for an accepted, non-excepting instruction.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic br,
                                           input logic [15:0] off, input logic j,
                                           input logic [25:0] idx, input logic jr,
                                           input logic [31:0] tgt);
    logic [31:0]        pc4;
    logic signed [31:0] disp;
    pc4  = pc + 32'd4;
    disp = $signed(off);
    if (jr) return tgt;
    if (j)  return (pc4 & 32'hF000_0000) | (32'(idx) << 2);
    if (br) return pc4 + disp * 4;
    return pc4;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
    rst        = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    id_ready   = 1'b0;
    br_take    = 1'b0;
    br_off     = 16'h0;
    j_take     = 1'b0;
    j_index    = 26'h0;
    jr_take    = 1'b0;
    jr_target  = 32'h0;
    exc_req    = 1'b0;
    halt       = 1'b0;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0000_3000);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_epc", epc, 0);
    check("rst_halted", halted, 0);
    exp_epc = 32'h0;
  endtask

  // Zero-wait fetch: request cycle, ack in the first wait cycle, then hold.
  task automatic fetch_zw(input logic [31:0] addr, input logic [31:0] data);
    next_cycle();
    @(negedge clk);
    check("fetch_req", imem_req, 1);
    check("fetch_addr", imem_addr, addr);
    check("fetch_valid", instr_valid, 0);
    next_cycle();
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    check("wait_req", imem_req, 1);
    next_cycle();
    @(negedge clk);
    check("hold_valid", instr_valid, 1);
    check("hold_instr_pc", instr_pc, addr);
    check("hold_instr", instr, data);
    check("hold_req", imem_req, 0);
    cur_hold = addr;
  endtask

  task automatic handshake(input logic br, input logic [15:0] off, input logic j,
                           input logic [25:0] idx, input logic jr, input logic [31:0] tgt,
                           input logic exc, input logic hlt);
    next_cycle();
    id_ready  = 1'b1;
    br_take   = br;
    br_off    = off;
    j_take    = j;
    j_index   = idx;
    jr_take   = jr;
    jr_target = tgt;
    exc_req   = exc;
    halt      = hlt;
    @(negedge clk);
    check("hs_valid", instr_valid, 1);
  endtask

  task automatic goto_hold(input logic [31:0] addr);
    handshake(0, 16'h0, 0, 26'h0, 1, addr, 0, 0);
    fetch_zw(addr, mem_word(addr));
  endtask

  task automatic plain_hs();
    handshake(0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0);
  endtask

  // Randomized traffic; the model tracks fetch/hold transactions only.
  task automatic random_run(input int cycles);
    logic        m_valid, m_discard, n_valid, n_discard;
    logic [31:0] m_fetch, m_hold, m_epc, n_fetch, n_hold, n_epc;
    int          m_age, n_age;
    logic        exc, rdy, br, j, jr, ack;
    logic [15:0] off;
    logic [25:0] idx;
    logic [31:0] tgt;
    m_valid = 0; m_discard = 0; m_fetch = 32'h0000_3000; m_hold = 0; m_epc = 0; m_age = 0;
    for (int c = 0; c < cycles; c++) begin
      next_cycle();
      n_valid = m_valid; n_discard = m_discard; n_fetch = m_fetch;
      n_hold = m_hold; n_epc = m_epc; n_age = m_age;
      exc = ($urandom_range(0, 99) < 6);
      if (m_valid) begin
        rdy = $urandom_range(0, 1);
        jr  = ($urandom_range(0, 99) < 15);
        j   = ($urandom_range(0, 99) < 20);
        br  = ($urandom_range(0, 99) < 30);
        off = 16'($urandom);
        idx = 26'($urandom);
        tgt = $urandom;
        if ($urandom_range(0, 3) != 0) tgt = tgt & 32'hFFFF_FFFC;
        id_ready = rdy; br_take = br; br_off = off; j_take = j; j_index = idx;
        jr_take = jr; jr_target = tgt; exc_req = exc;
        if (exc || (rdy && jr && (tgt % 4 != 0))) begin
          n_epc = m_hold; n_fetch = EXC_VEC; n_valid = 0; n_age = 0;
        end else if (rdy) begin
          n_fetch = ref_next(m_hold, br, off, j, idx, jr, tgt); n_valid = 0; n_age = 0;
        end
      end else begin
        ack = (m_age >= 1) && (($urandom_range(0, 2) == 0) || (m_age >= 4));
        exc_req    = exc;
        imem_ack   = ack;
        imem_rdata = ack ? mem_word(m_fetch) : $urandom;
        if (ack) begin
          if (m_discard || exc) begin
            n_epc = m_fetch; n_fetch = EXC_VEC; n_discard = 0;
          end else begin
            n_valid = 1; n_hold = m_fetch;
          end
          n_age = 0;
        end else if (exc && m_age == 0) begin
          n_epc = m_fetch; n_fetch = EXC_VEC;
        end else begin
          n_age = m_age + 1;
          if (exc) n_discard = 1;
        end
      end
      @(negedge clk);
      check("rnd_req", imem_req, !m_valid && !(exc && m_age == 0));
      if (!m_valid) check("rnd_addr", imem_addr, m_fetch);
      check("rnd_valid", instr_valid, m_valid);
      if (m_valid) begin
        check("rnd_instr_pc", instr_pc, m_hold);
        check("rnd_instr", instr, mem_word(m_hold));
      end
      check("rnd_epc", epc, m_epc);
      check("rnd_halted", halted, 0);
      m_valid = n_valid; m_discard = n_discard; m_fetch = n_fetch;
      m_hold = n_hold; m_epc = n_epc; m_age = n_age;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_miss = 0; exp_epc = 0; cur_hold = 0;
    rst = 1'b1; imem_ack = 0; imem_rdata = 0; id_ready = 0; br_take = 0; br_off = 0;
    j_take = 0; j_index = 0; jr_take = 0; jr_target = 0; exc_req = 0; halt = 0;

    vecs[0]  = '{32'h0000_3010, 0, 16'h0000, 1, 26'h000_0C40, 0, 32'h0, 0, 32'h0000_3100, 0};
    vecs[1]  = '{32'hF000_0000, 0, 16'h0000, 1, 26'h3FF_FFFF, 0, 32'h0, 0, 32'hFFFF_FFFC, 0};
    vecs[2]  = '{32'h0000_3000, 1, 16'hFFFF, 0, 26'h0,        0, 32'h0, 0, 32'h0000_3000, 0};
    vecs[3]  = '{32'h0000_3000, 1, 16'h0003, 0, 26'h0,        0, 32'h0, 0, 32'h0000_3010, 0};
    vecs[4]  = '{32'h0000_3000, 1, 16'h0003, 1, 26'h000_0010, 0, 32'h0, 0, 32'h0000_0040, 0};
    vecs[5]  = '{32'h0000_3000, 0, 16'h0000, 0, 26'h0,        1, 32'h0000_3002, 0, 32'h0000_4180, 1};
    vecs[6]  = '{32'h0000_3000, 0, 16'h0000, 0, 26'h0,        1, 32'h0000_5000, 0, 32'h0000_5000, 0};
    vecs[7]  = '{32'h0000_3000, 0, 16'h0000, 0, 26'h0,        1, 32'h0000_5000, 1, 32'h0000_4180, 1};
    vecs[8]  = '{32'hFFFF_FFFC, 0, 16'h0000, 0, 26'h0,        0, 32'h0, 0, 32'h0000_0000, 0};
    vecs[9]  = '{32'h0000_3000, 1, 16'h8000, 0, 26'h0,        0, 32'h0, 0, 32'hFFFE_3004, 0};
    vecs[10] = '{32'h0000_3000, 0, 16'h0000, 1, 26'h000_0001, 1, 32'h0000_6000, 0, 32'h0000_6000, 0};

    // Sequential fetch from reset with zero-wait memory.
    do_reset();
    fetch_zw(32'h0000_3000, 32'h2000_0001);
    plain_hs();
    fetch_zw(32'h0000_3004, 32'h2000_0001);
    plain_hs();
    fetch_zw(32'h0000_3008, 32'h2000_0001);

    // Redirect table.
    for (int i = 0; i < 11; i++) begin
      goto_hold(vecs[i].hold_pc);
      handshake(vecs[i].br, vecs[i].off, vecs[i].j, vecs[i].idx,
                vecs[i].jr, vecs[i].tgt, vecs[i].exc, 0);
      if (vecs[i].exp_exc) exp_epc = vecs[i].hold_pc;
      fetch_zw(vecs[i].exp_next, mem_word(vecs[i].exp_next));
      check("vec_epc", epc, exp_epc);
    end

    // exc_req in HOLD without handshake flushes the held word.
    next_cycle();
    exc_req = 1'b1;
    @(negedge clk);
    check("flush_valid_before", instr_valid, 1);
    exp_epc = cur_hold;
    fetch_zw(EXC_VEC, 32'h1111_2222);
    check("flush_epc", epc, exp_epc);

    // exc_req in FETCH: no request that cycle, retarget immediately.
    plain_hs();
    next_cycle();
    exc_req = 1'b1;
    @(negedge clk);
    check("fetch_exc_req", imem_req, 0);
    exp_epc = 32'h0000_4184;
    fetch_zw(EXC_VEC, 32'h3333_4444);
    check("fetch_exc_epc", epc, exp_epc);

    // Exception together with halt at the handshake: no halt.
    handshake(0, 16'h0, 0, 26'h0, 0, 32'h0, 1, 1);
    exp_epc = EXC_VEC;
    fetch_zw(EXC_VEC, 32'h5555_6666);
    check("exc_halt_halted", halted, 0);
    check("exc_halt_epc", epc, exp_epc);

    // exc_req and ack in the same WAIT cycle: data dropped.
    plain_hs();
    next_cycle();
    @(negedge clk);
    check("same_fetch_addr", imem_addr, 32'h0000_4184);
    next_cycle();
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0; exc_req = 1'b1;
    @(negedge clk);
    exp_epc = 32'h0000_4184;
    fetch_zw(EXC_VEC, 32'h7777_8888);
    check("same_epc", epc, exp_epc);

    // Halt at the handshake, then nothing moves, exc_req ignored.
    handshake(1, 16'h0003, 0, 26'h0, 0, 32'h0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      exc_req  = (k == 2);
      imem_ack = (k == 3);
      id_ready = 1'b1;
      @(negedge clk);
      check("halt_halted", halted, 1);
      check("halt_req", imem_req, 0);
      check("halt_valid", instr_valid, 0);
    end
    check("halt_epc", epc, exp_epc);

    // Reset in the middle of WAIT; the late ack lands in the reset cycle.
    do_reset();
    next_cycle();
    @(negedge clk);
    check("rw_fetch_addr", imem_addr, 32'h0000_3000);
    next_cycle();
    next_cycle();
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rw_valid", instr_valid, 0);
    check("rw_addr", imem_addr, 32'h0000_3000);
    check("rw_instr", instr, 0);
    fetch_zw(32'h0000_3000, 32'h1234_5678);

    // exc_req in WAIT with the ack delayed: fetch at 0x3008 is discarded.
    plain_hs();
    fetch_zw(32'h0000_3004, 32'h2000_0001);
    plain_hs();
    next_cycle();
    @(negedge clk);
    check("dw_fetch_addr", imem_addr, 32'h0000_3008);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      exc_req    = (k == 0);
      imem_ack   = (k == 3);
      imem_rdata = 32'hFEED_F00D;
      @(negedge clk);
      check("dw_req", imem_req, 1);
      check("dw_valid", instr_valid, 0);
    end
    exp_epc = 32'h0000_3008;
    fetch_zw(EXC_VEC, 32'h9999_AAAA);
    check("dw_epc", epc, exp_epc);

    // Randomized traffic against the transaction model.
    do_reset();
    random_run(2000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the single-issue core.
- Computes the next PC from four sources: sequential, branch, J-type jump, and JR. The jump target is the 4-bit PC region joined with the 26-bit index shifted left by 2.
- Runs a request/acknowledge handshake with instruction memory and a valid/ready handshake with decode.
- Redirects to the exception vector on request.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded by reset.
- EXC_VECTOR, 32'h0000_4180, exception entry address.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- imem_req  out  1  fetch request; held until imem_ack
- imem_addr  out  32  fetch address (= pc register)
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  32  fetched word
- instr_valid  out  1  instr/instr_pc valid to decode
- instr  out  32  held instruction
- instr_pc  out  32  address of held instruction
- id_ready  in  1  decode accepts held instruction this cycle
- br_take  in  1  branch taken for the accepted instruction
- br_off  in  16  branch offset in words, signed
- j_take  in  1  J/JAL for the accepted instruction
- j_index  in  26  jump index field
- jr_take  in  1  JR/JALR for the accepted instruction
- jr_target  in  32  register target
- exc_req  in  1  exception request, single-cycle pulse
- halt  in  1  stop fetching after the accepted instruction
- epc  out  32  PC saved on exception
- halted  out  1  sequencer is in HALTED

Behaviour:
- Reset (sync, rst=1 at the clk edge) sets:
  - pc=RESET_PC, state=FETCH, epc=0, exc_pend=0.
  - instr_valid=0, imem_req=0, instr=0, instr_pc=0, halted=0.
  - rst overrides everything, including an outstanding fetch. An imem_ack arriving in the reset cycle is ignored.
- States: FETCH, WAIT, HOLD, HALTED.
- FETCH: imem_req=1, imem_addr=pc; go to WAIT next cycle. imem_req stays 1 through WAIT.
- WAIT, on imem_ack:
  - If exc_pend=0: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, go to HOLD.
  - If exc_pend=1: discard the data, epc<=pc, pc<=EXC_VECTOR, clear exc_pend, go to FETCH.
  - imem_req drops the cycle after the ack.
- HOLD: instr_valid=1. On id_ready=1 (handshake), instr_valid<=0 and next pc is chosen by priority:
  1. exc_req: epc<=instr_pc, pc<=EXC_VECTOR.
  2. jr_take:
     - If jr_target[1:0]!=0: treated as an exception, epc<=instr_pc, pc<=EXC_VECTOR.
     - Otherwise pc<=jr_target.
  3. j_take: pc<={pc4[31:28], j_index, 2'b00}, where pc4=instr_pc+4.
  4. br_take: pc<=pc4 + {{14{br_off[15]}}, br_off, 2'b00}.
  5. Otherwise pc<=pc4.
  - Then go to FETCH, or to HALTED if halt=1 and no exception was taken.
  - There is no delay slot. All arithmetic is mod 2^32 (wraps, no flag).
- Redirect and halt inputs are ignored unless the HOLD handshake fires that cycle.
- exc_req in HOLD without id_ready: epc<=instr_pc, pc<=EXC_VECTOR, instr_valid<=0, go to FETCH. The held instruction is flushed.
- exc_req in WAIT: sets exc_pend. The outstanding fetch completes and is discarded (rule above).
- exc_req in FETCH: epc<=pc, pc<=EXC_VECTOR, no memory request issued. Stay in FETCH with the new pc.
- exc_req and imem_ack in the same WAIT cycle: treated as exc_pend=1 at the ack.
- HALTED:
  - halted=1, no requests, instr_valid=0, exc_req ignored.
  - Exited only by rst.
- Latency: redirect handshake in cycle N gives imem_req with the new address in cycle N+1. Zero-wait memory (ack in the first WAIT cycle) gives instr_valid in cycle N+3.

Decomposition:
- Package cpu_pc_pkg holds RESET_PC/EXC_VECTOR defaults and the state enum (FETCH, WAIT, HOLD, HALTED).
- One sub-module, pc_target_join: combinational; inputs pc4[31:28] and j_index; output the 32-bit jump target.
- Branch/JR/sequential muxing stays inline.

Test Plan:
- Reset, then zero-wait memory returning 0x2000_0001 at 0x3000 with id_ready=1: imem_addr sequence 0x3000, 0x3004, 0x3008. instr_pc tracks it; no redirect.
- HOLD at instr_pc=0x0000_3010, j_take=1, j_index=26'h000_0C40 -> next imem_addr=0x0000_3100. A second case with instr_pc=0xF000_0000, j_index=26'h3FF_FFFF -> 0xFFFF_FFFC.
- br_take at instr_pc=0x3000:
  - br_off=16'hFFFF -> next imem_addr=0x3000.
  - br_off=16'h0003 -> 0x3010.
  - br_take and j_take together -> jump target wins.
- jr_take with jr_target=0x0000_3002 -> pc=0x4180, epc=instr_pc. With 0x0000_5000 -> pc=0x5000.
- exc_req in WAIT (ack delayed 3 cycles, fetch addr 0x3008): data discarded, instr_valid stays 0, epc=0x3008, next fetch 0x4180.
- Handshake with halt=1 -> halted=1, imem_req=0 indefinitely. rst mid-WAIT -> fetch restarts at 0x3000 and the late ack is ignored.
